// File: rtl/id_ex_stage_buffer_pkg.sv
// Shared pipeline definitions for the ID->EX stage: default widths, NOP control
// encodings, the packed payload layout and the skid-register state encoding.
package pipeline_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
  localparam int unsigned DEF_EX_WIDTH       = 4;
  localparam int unsigned DEF_MEM_WIDTH      = 3;
  localparam int unsigned DEF_WB_WIDTH       = 2;

  localparam logic [DEF_EX_WIDTH-1:0]  NOP_EX  = '0;
  localparam logic [DEF_MEM_WIDTH-1:0] NOP_MEM = '0;
  localparam logic [DEF_WB_WIDTH-1:0]  NOP_WB  = '0;

  // Field order here is the bit order of the word carried through the skid register.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]     reg_a;
    logic [DEF_DATA_WIDTH-1:0]     reg_b;
    logic [DEF_DATA_WIDTH-1:0]     extendido;
    logic [DEF_DATA_WIDTH-1:0]     pc;
    logic [DEF_REG_ADDR_WIDTH-1:0] rs;
    logic [DEF_REG_ADDR_WIDTH-1:0] rt;
    logic [DEF_REG_ADDR_WIDTH-1:0] rd;
    logic [DEF_EX_WIDTH-1:0]       ex;
    logic [DEF_MEM_WIDTH-1:0]      mem;
    logic [DEF_WB_WIDTH-1:0]       wb;
  } id_ex_payload_t;

  // {skid_valid, main_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } skid_state_e;

  function automatic int unsigned payload_width(
    input int unsigned data_w, input int unsigned reg_w,
    input int unsigned ex_w, input int unsigned mem_w, input int unsigned wb_w
  );
    return 4 * data_w + 3 * reg_w + ex_w + mem_w + wb_w;
  endfunction

endpackage

// File: rtl/id_ex_stage_buffer_if.sv
// Valid/ready channel carrying one ID->EX instruction; master drives the payload.
interface id_ex_stage_buffer_if #(
  parameter int unsigned DATA_WIDTH     = pipeline_pkg::DEF_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = pipeline_pkg::DEF_REG_ADDR_WIDTH,
  parameter int unsigned EX_WIDTH       = pipeline_pkg::DEF_EX_WIDTH,
  parameter int unsigned MEM_WIDTH      = pipeline_pkg::DEF_MEM_WIDTH,
  parameter int unsigned WB_WIDTH       = pipeline_pkg::DEF_WB_WIDTH
);
  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     reg_a;
  logic [DATA_WIDTH-1:0]     reg_b;
  logic [DATA_WIDTH-1:0]     extendido;
  logic [DATA_WIDTH-1:0]     pc;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [EX_WIDTH-1:0]       ex;
  logic [MEM_WIDTH-1:0]      mem;
  logic [WB_WIDTH-1:0]       wb;

  modport master (
    output valid, reg_a, reg_b, extendido, pc, rs, rt, rd, ex, mem, wb,
    input  ready
  );

  modport slave (
    input  valid, reg_a, reg_b, extendido, pc, rs, rt, rd, ex, mem, wb,
    output ready
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry skid register: outputs always come from the main entry, the skid
// entry absorbs one beat of back-pressure so ready never depends on i_ready.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);
  import pipeline_pkg::*;

  skid_state_e      state, state_next;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             load_main_in, load_main_skid, load_skid;

  assign o_valid = (state != EMPTY);
  assign o_ready = (state != SKID);
  assign o_data  = main_data;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= EMPTY;
    else          state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (i_flush) begin
      // Flush wins over any concurrent accept; data registers keep their contents.
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (i_valid) begin
          load_main_in = 1'b1;
          state_next   = FULL;
        end
        FULL: begin
          if (i_valid && i_ready) begin
            load_main_in = 1'b1;
          end else if (i_valid) begin
            load_skid  = 1'b1;
            state_next = SKID;
          end else if (i_ready) begin
            state_next = EMPTY;
          end
        end
        SKID: if (i_ready) begin
          load_main_skid = 1'b1;
          state_next     = FULL;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in)        main_data <= i_data;
      else if (load_main_skid) main_data <= skid_data;
      if (load_skid)           skid_data <= i_data;
    end
  end

endmodule

// File: rtl/id_ex_stage_buffer.sv
// ID->EX stage register with valid/ready handshake, skid buffer, flush and NOP
// control on bubbles. Define ID_EX_PERF_CNT_EN to add stall/bubble counters.
module id_ex_stage_buffer #(
  parameter int unsigned DATA_WIDTH     = pipeline_pkg::DEF_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = pipeline_pkg::DEF_REG_ADDR_WIDTH,
  parameter int unsigned EX_WIDTH       = pipeline_pkg::DEF_EX_WIDTH,
  parameter int unsigned MEM_WIDTH      = pipeline_pkg::DEF_MEM_WIDTH,
  parameter int unsigned WB_WIDTH       = pipeline_pkg::DEF_WB_WIDTH
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_flush,
  id_ex_stage_buffer_if.slave  up,
  id_ex_stage_buffer_if.master dn
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]          o_stall_cnt,
  output logic [31:0]          o_bubble_cnt
`endif
);
  import pipeline_pkg::*;

  localparam int unsigned PAYLOAD_WIDTH =
    payload_width(DATA_WIDTH, REG_ADDR_WIDTH, EX_WIDTH, MEM_WIDTH, WB_WIDTH);

  logic [PAYLOAD_WIDTH-1:0] in_word, out_word;
  logic                     main_valid;
  logic [EX_WIDTH-1:0]      ex_held;
  logic [MEM_WIDTH-1:0]     mem_held;
  logic [WB_WIDTH-1:0]      wb_held;

  assign in_word = {up.reg_a, up.reg_b, up.extendido, up.pc,
                    up.rs, up.rt, up.rd, up.ex, up.mem, up.wb};

  pipe_skid_reg #(.WIDTH(PAYLOAD_WIDTH)) u_skid (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_flush (i_flush),
    .i_valid (up.valid),
    .o_ready (up.ready),
    .i_data  (in_word),
    .o_valid (main_valid),
    .i_ready (dn.ready),
    .o_data  (out_word)
  );

  assign {dn.reg_a, dn.reg_b, dn.extendido, dn.pc,
          dn.rs, dn.rt, dn.rd, ex_held, mem_held, wb_held} = out_word;

  // Control fields read as NOP whenever the slot is empty; data fields simply hold.
  assign dn.valid = main_valid;
  assign dn.ex    = main_valid ? ex_held  : EX_WIDTH'(NOP_EX);
  assign dn.mem   = main_valid ? mem_held : MEM_WIDTH'(NOP_MEM);
  assign dn.wb    = main_valid ? wb_held  : WB_WIDTH'(NOP_WB);

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_stall_cnt  <= '0;
      o_bubble_cnt <= '0;
    end else begin
      if (main_valid && !dn.ready && (o_stall_cnt != '1))
        o_stall_cnt <= o_stall_cnt + 32'd1;
      if (!main_valid && (o_bubble_cnt != '1))
        o_bubble_cnt <= o_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_buffer.sv
// Scoreboard bench for id_ex_stage_buffer: accepted instructions are queued and
// compared against the execute-side outputs while they are presented.
module tb_id_ex_stage_buffer;
  import pipeline_pkg::*;

  logic i_clock = 1'b0;
  logic i_reset;
  logic i_flush;

  always #5 i_clock = ~i_clock;

  id_ex_stage_buffer_if up_if ();
  id_ex_stage_buffer_if dn_if ();

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  id_ex_stage_buffer #(
    .DATA_WIDTH     (DEF_DATA_WIDTH),
    .REG_ADDR_WIDTH (DEF_REG_ADDR_WIDTH),
    .EX_WIDTH       (DEF_EX_WIDTH),
    .MEM_WIDTH      (DEF_MEM_WIDTH),
    .WB_WIDTH       (DEF_WB_WIDTH)
  ) u_dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_flush      (i_flush),
    .up           (up_if),
    .dn           (dn_if)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .o_stall_cnt  (stall_cnt),
    .o_bubble_cnt (bubble_cnt)
`endif
  );

  int unsigned    checks = 0;
  int unsigned    errors = 0;
  id_ex_payload_t exp_q[$];
  id_ex_payload_t last_main;
  logic [31:0]    exp_stall, exp_bubble;

  task automatic check_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic id_ex_payload_t rand_payload();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[$bits(id_ex_payload_t)-1:0];
  endfunction

  function automatic id_ex_payload_t mk(input logic [31:0] a);
    id_ex_payload_t p;
    p       = rand_payload();
    p.reg_a = a;
    return p;
  endfunction

  function automatic id_ex_payload_t out_payload();
    return {dn_if.reg_a, dn_if.reg_b, dn_if.extendido, dn_if.pc,
            dn_if.rs, dn_if.rt, dn_if.rd, dn_if.ex, dn_if.mem, dn_if.wb};
  endfunction

  task automatic drive(input logic v, input id_ex_payload_t p, input logic rdy, input logic fl);
    up_if.valid     = v;
    up_if.reg_a     = p.reg_a;
    up_if.reg_b     = p.reg_b;
    up_if.extendido = p.extendido;
    up_if.pc        = p.pc;
    up_if.rs        = p.rs;
    up_if.rt        = p.rt;
    up_if.rd        = p.rd;
    up_if.ex        = p.ex;
    up_if.mem       = p.mem;
    up_if.wb        = p.wb;
    dn_if.ready     = rdy;
    i_flush         = fl;
  endtask

  task automatic check_outputs();
    id_ex_payload_t o;
    o = out_payload();
    check_eq("o_ready", {159'd0, up_if.ready}, {159'd0, exp_q.size() < 2});
    check_eq("o_valid", {159'd0, dn_if.valid}, {159'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check_eq("payload", o, exp_q[0]);
    end else begin
      check_eq("bubble_ctrl", {o.ex, o.mem, o.wb}, '0);
      check_eq("held_data", {o.reg_a, o.reg_b, o.extendido, o.pc, o.rs, o.rt, o.rd},
               {last_main.reg_a, last_main.reg_b, last_main.extendido, last_main.pc,
                last_main.rs, last_main.rt, last_main.rd});
    end
`ifdef ID_EX_PERF_CNT_EN
    check_eq("stall_cnt", stall_cnt, exp_stall);
    check_eq("bubble_cnt", bubble_cnt, exp_bubble);
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_main  = '0;
    exp_stall  = '0;
    exp_bubble = '0;
  endtask

  // Check current outputs, present one cycle of stimulus, advance the model across the edge.
  task automatic cycle(input logic v, input id_ex_payload_t p, input logic rdy, input logic fl);
    bit acc, xfer;
    check_outputs();
    drive(v, p, rdy, fl);
    acc  = v && (exp_q.size() < 2);
    xfer = (exp_q.size() != 0) && rdy;
    if ((exp_q.size() != 0) && !rdy && (exp_stall != '1)) exp_stall++;
    if ((exp_q.size() == 0) && (exp_bubble != '1)) exp_bubble++;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (xfer) void'(exp_q.pop_front());
      if (acc)  exp_q.push_back(p);
    end
    if (exp_q.size() != 0) last_main = exp_q[0];
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle(input int unsigned n, input logic rdy);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, rand_payload(), rdy, 1'b0);
  endtask

  initial begin
    id_ex_payload_t bub;
    i_reset = 1'b0;
    model_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'($urandom()), rand_payload(), 1'($urandom()), 1'($urandom()));
      @(posedge i_clock);
      #1;
      check_outputs();
    end
    i_reset = 1'b1;

    // First instruction after reset, then an 8-deep stream
    cycle(1'b1, mk(32'h11), 1'b1, 1'b0);
    for (int unsigned i = 1; i <= 8; i++) cycle(1'b1, mk(i), 1'b1, 1'b0);
    idle(2, 1'b1);

    // Back-pressure into the skid entry, then drain in order
    cycle(1'b1, mk(32'hA), 1'b1, 1'b0);
    cycle(1'b1, mk(32'hB), 1'b0, 1'b0);
    cycle(1'b0, rand_payload(), 1'b0, 1'b0);
    idle(3, 1'b1);

    // Flush while in SKID with a new instruction offered
    cycle(1'b1, mk(32'hA), 1'b0, 1'b0);
    cycle(1'b1, mk(32'hB), 1'b0, 1'b0);
    cycle(1'b1, mk(32'hC), 1'b0, 1'b1);
    idle(2, 1'b1);

    // Flush beats a simultaneous accept in FULL
    cycle(1'b1, mk(32'hD), 1'b1, 1'b0);
    cycle(1'b1, mk(32'hE), 1'b1, 1'b1);
    idle(2, 1'b1);

    // Bubble after an all-ones control word
    bub = mk(32'h5A);
    bub.ex = '1; bub.mem = '1; bub.wb = '1;
    cycle(1'b1, bub, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Stalls then empties, then a flush that must leave the counters alone
    cycle(1'b1, mk(32'h77), 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(4, 1'b1);
    cycle(1'b0, rand_payload(), 1'b1, 1'b1);
    idle(1, 1'b1);

    // Randomised traffic
    for (int unsigned i = 0; i < 300; i++)
      cycle(1'($urandom()), rand_payload(), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0));

    // Asynchronous reset in the middle of a cycle while holding two entries
    cycle(1'b1, mk(32'h91), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h92), 1'b0, 1'b0);
    check_outputs();
    #2;
    i_reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    check_outputs();
    cycle(1'b1, mk(32'h93), 1'b1, 1'b0);
    idle(2, 1'b1);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
